uart_rx: RTL and testbench

Oversampling UART receiver that sits directly downstream of the baud-rate generator. It consumes the generator's 16x-oversampling tick and the raw serial line. It recovers LSB-first asynchronous frames: 1 start bit, DBIT data bits, optional parity, and a stop bit. Each received word is presented to the FIFO/bus side with a one-cycle done strobe and error flags.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 30 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path (package uart_pkg).
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Stop-bit counting needs a fifth tick-counter bit once it exceeds one bit period.
    function automatic int tick_width(input int sb_tick);
        return (sb_tick > OVERSAMPLE) ? 5 : 4;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and word-side signals of the UART receiver, bundled for port lists.
// rx_done_o is a valid-only strobe: one cycle per word, no ready/backpressure; the consumer must take dout_o that cycle or later before the next strobe.
interface uart_rx_if #(parameter int DBIT = 8);

    logic            s_tick_i;
    logic            rx_i;
    logic [DBIT-1:0] dout_o;
    logic            rx_done_o;
    logic            frame_err_o;
    logic            parity_err_o;

    modport slave (
        input  s_tick_i,
        input  rx_i,
        output dout_o,
        output rx_done_o,
        output frame_err_o,
        output parity_err_o
    );

    modport master (
        output s_tick_i,
        output rx_i,
        input  dout_o,
        input  rx_done_o,
        input  frame_err_o,
        input  parity_err_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: start/DATA/stop framing, LSB first, one-cycle done strobe.
// Define UART_RX_PARITY_EN to compile in an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    uart_rx_if.slave   bus,
    output logic [2:0] state_dbg
);

    localparam int SW = tick_width(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    localparam logic [SW-1:0] S_MID      = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    logic            rx_s;
    logic            rx_prev;
    logic [2:0]      state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            ferr_q;
`ifdef UART_RX_PARITY_EN
    logic            par_q;
    logic            perr_q;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (bus.rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_prev <= 1'b1;
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_prev <= rx_s;
            done_q  <= 1'b0;
            case (state_q)
                // Edge-triggered so a held-low break cannot restart a frame.
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (bus.s_tick_i) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.s_tick_i) begin
                        if (s_q == S_BIT_END) begin
                            b_q <= {rx_s, b_q[DBIT-1:1]};
                            s_q <= '0;
                            if (n_q == N_LAST) state_q <= ST_AFTER_DATA;
                            else               n_q     <= n_q + NW'(1);
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bus.s_tick_i) begin
                        if (s_q == S_BIT_END) begin
                            par_q   <= rx_s;
                            state_q <= ST_STOP;
                            s_q     <= '0;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
`endif
                // Word is delivered even on a framing error; the consumer decides.
                ST_STOP: begin
                    if (bus.s_tick_i) begin
                        if (s_q == S_STOP_END) begin
                            state_q <= ST_IDLE;
                            dout_q  <= b_q;
                            ferr_q  <= ~rx_s;
                            done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ^{b_q, par_q};
`endif
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dout_o      = dout_q;
    assign bus.rx_done_o   = done_q;
    assign bus.frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = perr_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit on rx_i and the
// expected words come from the frame contents themselves (data, stop level, parity).
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int BIT_CLKS = 64;
    localparam int W        = DBIT + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;
    int         tcnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    uart_rx_if #(.DBIT(DBIT)) bus();

    uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / tick ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt = (tcnt + 1) % 4;
        bus.s_tick_i = (tcnt == 0);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.rx_done_o === 1'b1)
            obs_q.push_back({bus.dout_o, bus.frame_err_o, bus.parity_err_o});
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic v);
        bus.rx_i = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_clks(input int n);
        bus.rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Expected word: the data as sent, frame error when the stop bit was low,
    // parity error when data XOR parity bit is odd (even parity).
    task automatic send_frame(input logic [DBIT-1:0] data, input logic stop_v, input logic par_v);
        logic perr;
        send_bit(1'b0);
        for (int i = 0; i < DBIT; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_v);
        perr = (^data) ^ par_v;
`else
        perr = 1'b0 & par_v;
`endif
        send_bit(stop_v);
        exp_q.push_back({data, ~stop_v, perr});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.dout_o !== '0) begin n_err++; $display("FAIL reset_dout got=%h exp=0", bus.dout_o); end
        n_cmp++; if (bus.rx_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.rx_done_o); end
        n_cmp++; if (bus.frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err_o); end
        n_cmp++; if (bus.parity_err_o !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err_o); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (state_dbg !== 3'(IDLE)) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    endtask

    task automatic test_single();
        logic [W-1:0] o, e;
        send_frame(8'h55, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] o, e;
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL b2b_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        bus.rx_i = 1'b0;
        repeat (12) @(negedge clk);
        idle_clks(3 * BIT_CLKS);
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL glitch_count got=%0d exp=0", obs_q.size()); end
        n_cmp++; if (state_dbg !== 3'(IDLE)) begin n_err++; $display("FAIL glitch_state got=%0d exp=%0d", state_dbg, IDLE); end
        obs_q.delete();
    endtask

    task automatic test_frame_err_break();
        logic [W-1:0] o, e;
        send_frame(8'h3C, 1'b0, 1'b0);
        bus.rx_i = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge clk);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL break_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL ferr_word got=%h exp=%h", o, e); end
        end
        n_cmp++; if (bus.frame_err_o !== 1'b1) begin n_err++; $display("FAIL ferr_hold got=%b exp=1", bus.frame_err_o); end
        obs_q.delete(); exp_q.delete();
        idle_clks(2 * BIT_CLKS);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL after_break_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL after_break_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] o, e;
        send_bit(1'b0);
        bus.rx_i = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.dout_o !== '0) begin n_err++; $display("FAIL midrst_dout got=%h exp=0", bus.dout_o); end
        n_cmp++; if (bus.frame_err_o !== 1'b0) begin n_err++; $display("FAIL midrst_ferr got=%b exp=0", bus.frame_err_o); end
        n_cmp++; if (bus.parity_err_o !== 1'b0) begin n_err++; $display("FAIL midrst_perr got=%b exp=0", bus.parity_err_o); end
        idle_clks(BIT_CLKS / 2 + 6 * BIT_CLKS);
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL midrst_count got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
        send_frame(8'h81, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL post_rst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL post_rst_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] o, e;
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL parity_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL parity_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] o, e;
        for (int i = 0; i < 12; i++) begin
            send_frame(DBIT'($urandom), 1'b1, 1'($urandom_range(0, 1)));
            idle_clks($urandom_range(0, 2) * BIT_CLKS + $urandom_range(0, 20));
        end
        idle_clks(BIT_CLKS);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL random_word got=%h exp=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.rx_i     = 1'b1;
        bus.s_tick_i = 1'b0;
        @(negedge clk);
        test_reset();
        idle_clks(2 * BIT_CLKS);
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
